// File: rtl/seq_pkg.sv
// ============================================================================
// Module  : seq_pkg
// Brief   : Shared encodings and constants for the sequence generator/detector family.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT,
        S_GAP   = ST_GAP,
        S_DONE  = ST_DONE
    } state_t;

    // Pattern shared with the overlapping Moore detector blocks
    localparam logic [3:0] DEFAULT_PATTERN = 4'b1010;

    localparam int MAX_GAP = 15;
    localparam int GAP_W   = 4;

endpackage

`default_nettype wire

// File: rtl/seq_down_cnt.sv
// ============================================================================
// Module  : seq_down_cnt
// Brief   : Loadable down-counter with zero flag; holds at zero.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_down_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic [W-1:0] cnt_next_o,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign zero_o = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && !zero_o) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o      = cnt_q;
    assign cnt_next_o = cnt_d;

endmodule

`default_nettype wire

// File: rtl/seq_pattern_tx.sv
// ============================================================================
// Module  : seq_pattern_tx
// Brief   : Serial MSB-first pattern transmitter with repeat count and idle gap.
//           Optional even-parity bit per repetition: SEQ_PATTERN_TX_PARITY_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEFAULT_PATTERN),
    parameter int               CNT_W   = 4,
    parameter int               GAP     = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] rep_cnt,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             done
);

`ifdef SEQ_PATTERN_TX_PARITY_EN
    localparam int PAR_EN = 1;
`else
    localparam int PAR_EN = 0;
`endif

    localparam int               NBITS    = PAT_W + PAR_EN;
    localparam int               BIT_W    = 4;
    localparam logic [BIT_W-1:0] c_BIT_LD = BIT_W'(NBITS - 1);
    localparam logic [BIT_W-1:0] c_PAR_OFS = BIT_W'(PAR_EN);
    localparam logic [GAP_W-1:0] c_GAP_LD = (GAP > 0) ? GAP_W'(GAP - 1) : '0;
    localparam logic             c_PARITY = ^PATTERN;

    state_t state_q, state_d;

    logic             bit_load, bit_dec, bit_zero;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic             rep_load, rep_dec, rep_zero;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic             gap_load, gap_dec, gap_zero;
    logic [GAP_W-1:0] gap_q, gap_d;

    logic             dout_d, dout_valid_d, busy_d, done_d;
    logic [PAT_W-1:0] pat_sh;

    seq_down_cnt #(.W(BIT_W)) u_bit_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (bit_load),
        .load_val_i (c_BIT_LD),
        .dec_i      (bit_dec),
        .cnt_o      (bit_q),
        .cnt_next_o (bit_d),
        .zero_o     (bit_zero)
    );

    seq_down_cnt #(.W(CNT_W)) u_rep_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (rep_load),
        .load_val_i (rep_cnt),
        .dec_i      (rep_dec),
        .cnt_o      (rep_q),
        .cnt_next_o (rep_d),
        .zero_o     (rep_zero)
    );

    seq_down_cnt #(.W(GAP_W)) u_gap_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (gap_load),
        .load_val_i (c_GAP_LD),
        .dec_i      (gap_dec),
        .cnt_o      (gap_q),
        .cnt_next_o (gap_d),
        .zero_o     (gap_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // rep counter holds "repetitions still to send after the current one",
    // so an all-ones rep_cnt yields 2^CNT_W patterns without wrapping.
    always_comb begin
        state_d  = state_q;
        bit_load = 1'b0;
        bit_dec  = 1'b0;
        rep_load = 1'b0;
        rep_dec  = 1'b0;
        gap_load = 1'b0;
        gap_dec  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_SHIFT;
                    bit_load = 1'b1;
                    rep_load = 1'b1;
                end
            end
            S_SHIFT: begin
                if (!bit_zero) begin
                    bit_dec = 1'b1;
                end else if (rep_zero) begin
                    state_d = S_DONE;
                end else begin
                    rep_dec = 1'b1;
                    if (GAP > 0) begin
                        state_d  = S_GAP;
                        gap_load = 1'b1;
                    end else begin
                        bit_load = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (gap_zero) begin
                    state_d  = S_SHIFT;
                    bit_load = 1'b1;
                end else begin
                    gap_dec = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered copy lines
    // up with the state it describes.
    always_comb begin
        dout_d       = 1'b0;
        dout_valid_d = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        pat_sh       = '0;
        case (state_d)
            S_SHIFT: begin
                dout_valid_d = 1'b1;
                busy_d       = 1'b1;
                if ((PAR_EN != 0) && (bit_d == '0)) begin
                    dout_d = c_PARITY;
                end else begin
                    pat_sh = PATTERN >> (bit_d - c_PAR_OFS);
                    dout_d = pat_sh[0];
                end
            end
            S_GAP: begin
                busy_d = 1'b1;
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            dout       <= dout_d;
            dout_valid <= dout_valid_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

    logic unused_ok;
    assign unused_ok = ^{bit_q, rep_q, rep_d, gap_q, gap_d};

endmodule

`default_nettype wire
